// File: rtl/disp_pkg.sv
// Shared types and constants for the display datapath (BCD converter and seven-segment driver).
package disp_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } disp_state_t;

  localparam int          DISP_DIGITS      = 4;
  localparam int          DISP_BIN_W       = 16;
  localparam int          DISP_ITER        = 16;
  localparam logic [15:0] DISP_OVF_PATTERN = 16'hEEEE;

endpackage

// File: rtl/disp_bcd_adj3.sv
// Double-dabble correction cell: a BCD nibble of 5 or more gets +3 so the next shift carries correctly.
module disp_bcd_adj3 (
  input  logic [3:0] d,
  output logic [3:0] q
);

  assign q = (d >= 4'd5) ? d + 4'd3 : d;

endmodule

// File: rtl/disp_bcd_conv.sv
// Iterative 16-bit binary to 4-digit packed BCD converter (double dabble, one bit per cycle).
// Define DISP_BCD_OVF_EN to show EEEE and raise ovf for inputs above 9999; otherwise value is input mod 10000.
module disp_bcd_conv
  import disp_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic [DISP_BIN_W-1:0]     in_data,
  output logic                      in_ready,
  output logic [4*DISP_DIGITS-1:0]  value,
  output logic                      busy,
  output logic                      ovf
);

  localparam int SCR_NIB = DISP_DIGITS + 1;
  localparam int SCR_W   = 4 * SCR_NIB;

  disp_state_t           state;
  logic [DISP_BIN_W-1:0] bin;
  logic [SCR_W-1:0]      scratch;
  logic [SCR_W-1:0]      adj;
  logic [3:0]            cnt;
  logic                  unused_adj_msb;

  // All five nibbles are corrected in parallel before each shift.
  for (genvar i = 0; i < SCR_NIB; i++) begin : g_adj
    disp_bcd_adj3 u_adj (
      .d(scratch[4*i +: 4]),
      .q(adj[4*i +: 4])
    );
  end

  // A 16-bit input never reaches bit 19 of the scratch, so this bit only falls off the top.
  assign unused_adj_msb = adj[SCR_W-1];

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

`ifdef DISP_BCD_OVF_EN
  logic ovf_q;
  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      bin     <= '0;
      scratch <= '0;
      cnt     <= '0;
      value   <= '0;
`ifdef DISP_BCD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            bin     <= in_data;
            scratch <= '0;
            cnt     <= '0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          {scratch, bin} <= {adj[SCR_W-2:0], bin, 1'b0};
          cnt            <= cnt + 4'd1;
          if (cnt == 4'(DISP_ITER - 1)) begin
            state <= COMMIT;
          end
        end
        COMMIT: begin
`ifdef DISP_BCD_OVF_EN
          if (scratch[SCR_W-1 -: 4] != 4'd0) begin
            value <= DISP_OVF_PATTERN;
            ovf_q <= 1'b1;
          end else begin
            value <= scratch[4*DISP_DIGITS-1:0];
            ovf_q <= 1'b0;
          end
`else
          value <= scratch[4*DISP_DIGITS-1:0];
`endif
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_disp_bcd_conv.sv
// Directed self-checking bench for disp_bcd_conv; expectations follow DISP_BCD_OVF_EN when defined.
module tb_disp_bcd_conv;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic [15:0] value;
  logic        busy;
  logic        ovf;

  int checks;
  int errors;

  disp_bcd_conv dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_valid(in_valid),
    .in_data (in_data),
    .in_ready(in_ready),
    .value   (value),
    .busy    (busy),
    .ovf     (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 ns after each rising edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s observed %h expected %h", tag, observed, expected);
      end
  endtask

  // Present one word, let it be accepted, then wait out SHIFT and COMMIT.
  task automatic applyStimulus(input logic [15:0] data);
    in_valid = 1'b1;
    in_data  = data;
    tick();
    in_valid = 1'b0;
    tick(17);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    tick(3);
    rst_n = 1'b1;
    tick();
    checkOutput("rst_value", value, 16'h0000);
    checkOutput("rst_ovf", {15'd0, ovf}, 16'd0);
    checkOutput("rst_busy", {15'd0, busy}, 16'd0);
    checkOutput("rst_ready", {15'd0, in_ready}, 16'd1);

    // Basic conversion with exact commit timing
    in_valid = 1'b1;
    in_data  = 16'd1234;
    tick();
    in_valid = 1'b0;
    checkOutput("acc_busy", {15'd0, busy}, 16'd1);
    checkOutput("acc_ready", {15'd0, in_ready}, 16'd0);
    tick(16);
    checkOutput("n16_busy", {15'd0, busy}, 16'd1);
    checkOutput("n16_value_old", value, 16'h0000);
    tick();
    checkOutput("n17_value", value, 16'h1234);
    checkOutput("n17_ovf", {15'd0, ovf}, 16'd0);
    checkOutput("n17_busy", {15'd0, busy}, 16'd0);
    checkOutput("n17_ready", {15'd0, in_ready}, 16'd1);

    applyStimulus(16'd9999);
    checkOutput("v9999", value, 16'h9999);
    checkOutput("v9999_ovf", {15'd0, ovf}, 16'd0);
    applyStimulus(16'd0);
    checkOutput("v0", value, 16'h0000);
    applyStimulus(16'd10000);
`ifdef DISP_BCD_OVF_EN
    checkOutput("v10000", value, 16'hEEEE);
    checkOutput("v10000_ovf", {15'd0, ovf}, 16'd1);
`else
    checkOutput("v10000", value, 16'h0000);
    checkOutput("v10000_ovf", {15'd0, ovf}, 16'd0);
`endif
    applyStimulus(16'd65535);
`ifdef DISP_BCD_OVF_EN
    checkOutput("v65535", value, 16'hEEEE);
    checkOutput("v65535_ovf", {15'd0, ovf}, 16'd1);
`else
    checkOutput("v65535", value, 16'h5535);
    checkOutput("v65535_ovf", {15'd0, ovf}, 16'd0);
`endif
    applyStimulus(16'd5678);
    checkOutput("v5678", value, 16'h5678);
    checkOutput("v5678_ovf", {15'd0, ovf}, 16'd0);

    // Busy blocking: 7 offered during SHIFT must be ignored
    in_valid = 1'b1;
    in_data  = 16'd42;
    tick();
    in_data = 16'd7;
    tick(3);
    checkOutput("blk_ready", {15'd0, in_ready}, 16'd0);
    tick(7);
    in_valid = 1'b0;
    tick(7);
    checkOutput("blk_value", value, 16'h0042);
    tick(20);
    checkOutput("blk_hold", value, 16'h0042);
    checkOutput("blk_idle", {15'd0, busy}, 16'd0);
    applyStimulus(16'd7);
    checkOutput("v7", value, 16'h0007);

    // Reset in the middle of SHIFT
    in_valid = 1'b1;
    in_data  = 16'd9876;
    tick();
    in_valid = 1'b0;
    tick(8);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_value", value, 16'h0000);
    checkOutput("mid_rst_busy", {15'd0, busy}, 16'd0);
    tick();
    rst_n = 1'b1;
    tick();
    checkOutput("post_rst_ready", {15'd0, in_ready}, 16'd1);
    applyStimulus(16'd321);
    checkOutput("v321", value, 16'h0321);

    // Back-to-back with in_valid held high
    in_valid = 1'b1;
    in_data  = 16'd1111;
    tick();
    in_data = 16'd2222;
    tick(17);
    checkOutput("b2b_first", value, 16'h1111);
    checkOutput("b2b_ready", {15'd0, in_ready}, 16'd1);
    tick();
    checkOutput("b2b_accept18", {15'd0, busy}, 16'd1);
    in_valid = 1'b0;
    tick(16);
    checkOutput("b2b_hold", value, 16'h1111);
    tick();
    checkOutput("b2b_second", value, 16'h2222);
    tick(5);
    checkOutput("b2b_no_third", {15'd0, busy}, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
